gpio_control_bank: RTL and testbench



---
 rtl/gpio_ctrl_pkg.sv | 28 ++
 rtl/gpio_ctrl_channel.sv | 89 ++++++++
 rtl/gpio_control_bank.sv | 154 +++++++++++++++
 tb/tb_gpio_control_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg
//   Shared definitions for the GPIO control bank: config field offsets within
//   one channel's PAD_CTRL_BITS-wide register, the default channel width and
//   the load FSM state encoding.
package gpio_ctrl_pkg;

    // Bit offsets inside one channel config word
    localparam int MGMT_EN = 0;
    localparam int OEB     = 1;
    localparam int HLDH    = 2;
    localparam int INP_DIS = 3;
    localparam int MOD_SEL = 4;
    localparam int AN_EN   = 5;
    localparam int AN_SEL  = 6;
    localparam int AN_POL  = 7;
    localparam int SLOW    = 8;
    localparam int TRIP    = 9;
    localparam int DM      = 10;    // 3-bit drive mode, [DM+2:DM]

    localparam int PAD_CTRL_BITS_DEF = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/gpio_ctrl_channel.sv
// gpio_ctrl_channel
//   One pad channel: the config register (reset to cfg_default, overwritten
//   by load_data on the load strobe) and the combinational pad mux that picks
//   management or user drive.
//   Optional GPIO_CTRL_READBACK_EN: exposes the live config word on cfg_q.
// Ports:
//   serial_clock, reset       block clock, synchronous active-high reset
//   cfg_default               power-on config word
//   load, load_data           commit strobe and the chain slice to commit
//   cfg_q                     live config (readback build only)
//   mgmt_*, user_*            management / user side drive, oeb and input
//   pad_*                     static pad config, muxed drive and pad input
module gpio_ctrl_channel
    import gpio_ctrl_pkg::*;
#(
    parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEF
) (
    input  logic                     serial_clock,
    input  logic                     reset,
    input  logic [PAD_CTRL_BITS-1:0] cfg_default,
    input  logic                     load,
    input  logic [PAD_CTRL_BITS-1:0] load_data,
`ifdef GPIO_CTRL_READBACK_EN
    output logic [PAD_CTRL_BITS-1:0] cfg_q,
`endif
    input  logic                     user_power_good,
    input  logic                     mgmt_out,
    input  logic                     mgmt_oeb,
    output logic                     mgmt_in,
    input  logic                     user_out,
    input  logic                     user_oeb,
    output logic                     user_in,
    output logic                     pad_holdover,
    output logic                     pad_slow_sel,
    output logic                     pad_vtrip_sel,
    output logic                     pad_inenb,
    output logic                     pad_ib_mode_sel,
    output logic                     pad_ana_en,
    output logic                     pad_ana_sel,
    output logic                     pad_ana_pol,
    output logic [2:0]               pad_dm,
    output logic                     pad_outenb,
    output logic                     pad_out,
    input  logic                     pad_in
);

    logic [PAD_CTRL_BITS-1:0] cfg;

    always_ff @(posedge serial_clock) begin
        if (reset)
            cfg <= cfg_default;
        else if (load)
            cfg <= load_data;
    end

`ifdef GPIO_CTRL_READBACK_EN
    assign cfg_q = cfg;
`endif

    assign pad_holdover    = cfg[HLDH];
    assign pad_slow_sel    = cfg[SLOW];
    assign pad_vtrip_sel   = cfg[TRIP];
    assign pad_inenb       = cfg[INP_DIS];
    assign pad_ib_mode_sel = cfg[MOD_SEL];
    assign pad_ana_en      = cfg[AN_EN];
    assign pad_ana_sel     = cfg[AN_SEL];
    assign pad_ana_pol     = cfg[AN_POL];
    assign pad_dm          = cfg[DM +: 3];

    assign mgmt_in = pad_in;
    assign user_in = pad_in & user_power_good;

    // Drive modes 3'b010 / 3'b011 emulate pull-down / pull-up: the pad is
    // driven with the inverse of dm[0] instead of the management data.
    always_comb begin
        pad_outenb = user_oeb;
        pad_out    = user_out;
        if (cfg[MGMT_EN]) begin
            if (mgmt_oeb) begin
                pad_outenb = cfg[OEB];
                pad_out    = (cfg[DM+2 -: 2] == 2'b01) ? ~cfg[DM] : mgmt_out;
            end else begin
                pad_outenb = 1'b0;
                pad_out    = mgmt_out;
            end
        end
    end

endmodule

// File: rtl/gpio_control_bank.sv
// gpio_control_bank
//   NUM_GPIO pad channels sharing one serial config chain of
//   NUM_GPIO*PAD_CTRL_BITS bits. shift_en shifts serial_data_in into the
//   chain; serial_load requests a commit one cycle later, gated on the frame
//   length when STRICT_LOAD=1. load_done / load_err report the outcome.
//   Optional GPIO_CTRL_READBACK_EN: adds readback_capture, which copies the
//   live config into the chain so it can be streamed out on serial_data_out.
// Ports:
//   serial_clock, reset                 clock, synchronous active-high reset
//   gpio_defaults                       power-on config, channel k at [k*P +: P]
//   shift_en, serial_data_in            chain shift strobe and data
//   serial_load                         commit request strobe
//   serial_data_out                     registered chain MSB
//   load_done, load_err                 one-cycle commit / reject pulses
//   readback_capture                    config-to-chain copy (readback build)
//   mgmt_*, user_*, pad_*               per-channel pad interface
module gpio_control_bank
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_GPIO      = 4,
    parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEF,
    parameter bit STRICT_LOAD   = 1'b1
) (
    input  logic                              serial_clock,
    input  logic                              reset,
    input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0] gpio_defaults,
    input  logic                              shift_en,
    input  logic                              serial_data_in,
    input  logic                              serial_load,
    output logic                              serial_data_out,
    output logic                              load_done,
    output logic                              load_err,
`ifdef GPIO_CTRL_READBACK_EN
    input  logic                              readback_capture,
`endif
    input  logic                              user_power_good,
    input  logic [NUM_GPIO-1:0]               mgmt_gpio_out,
    input  logic [NUM_GPIO-1:0]               mgmt_gpio_oeb,
    output logic [NUM_GPIO-1:0]               mgmt_gpio_in,
    input  logic [NUM_GPIO-1:0]               user_gpio_out,
    input  logic [NUM_GPIO-1:0]               user_gpio_oeb,
    output logic [NUM_GPIO-1:0]               user_gpio_in,
    output logic [NUM_GPIO-1:0]               pad_gpio_holdover,
    output logic [NUM_GPIO-1:0]               pad_gpio_slow_sel,
    output logic [NUM_GPIO-1:0]               pad_gpio_vtrip_sel,
    output logic [NUM_GPIO-1:0]               pad_gpio_inenb,
    output logic [NUM_GPIO-1:0]               pad_gpio_ib_mode_sel,
    output logic [NUM_GPIO-1:0]               pad_gpio_ana_en,
    output logic [NUM_GPIO-1:0]               pad_gpio_ana_sel,
    output logic [NUM_GPIO-1:0]               pad_gpio_ana_pol,
    output logic [3*NUM_GPIO-1:0]             pad_gpio_dm,
    output logic [NUM_GPIO-1:0]               pad_gpio_outenb,
    output logic [NUM_GPIO-1:0]               pad_gpio_out,
    input  logic [NUM_GPIO-1:0]               pad_gpio_in
);

    localparam int TOTAL = NUM_GPIO * PAD_CTRL_BITS;
    localparam int CW    = $clog2(TOTAL + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TOTAL + 1);   // overrun marker

    state_t           state;
    logic [TOTAL-1:0] sr;
    logic [CW-1:0]    bit_cnt;
    logic             frame_ok;
    logic             commit;
    logic             rb;

`ifdef GPIO_CTRL_READBACK_EN
    logic [TOTAL-1:0] cfg_flat;
    assign rb = readback_capture;
`else
    assign rb = 1'b0;
`endif

    assign frame_ok = (bit_cnt == CNT_FULL) || !STRICT_LOAD;
    assign commit   = (state == CHECK) && frame_ok;

    // Strobes arriving during CHECK are dropped entirely; the driver is
    // expected to leave one idle cycle after serial_load.
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            state           <= IDLE;
            sr              <= '0;
            bit_cnt         <= '0;
            serial_data_out <= 1'b0;
            load_done       <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (state == CHECK) begin
                load_done <= frame_ok;
                load_err  <= !frame_ok;
                bit_cnt   <= '0;
                state     <= IDLE;
            end else begin
                if (rb) begin
`ifdef GPIO_CTRL_READBACK_EN
                    sr <= cfg_flat;
`endif
                    bit_cnt <= '0;
                end else if (shift_en) begin
                    sr              <= {sr[TOTAL-2:0], serial_data_in};
                    serial_data_out <= sr[TOTAL-1];
                    if (bit_cnt != CNT_SAT)
                        bit_cnt <= bit_cnt + 1'b1;
                end
                // A load in the same cycle as a shift sees the post-shift chain.
                if (serial_load)
                    state <= CHECK;
                else if (rb)
                    state <= IDLE;
                else if (shift_en)
                    state <= SHIFT;
            end
        end
    end

    for (genvar k = 0; k < NUM_GPIO; k++) begin : g_ch
        gpio_ctrl_channel #(
            .PAD_CTRL_BITS (PAD_CTRL_BITS)
        ) u_ch (
            .serial_clock    (serial_clock),
            .reset           (reset),
            .cfg_default     (gpio_defaults[k*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
            .load            (commit),
            .load_data       (sr[k*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
`ifdef GPIO_CTRL_READBACK_EN
            .cfg_q           (cfg_flat[k*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
`endif
            .user_power_good (user_power_good),
            .mgmt_out        (mgmt_gpio_out[k]),
            .mgmt_oeb        (mgmt_gpio_oeb[k]),
            .mgmt_in         (mgmt_gpio_in[k]),
            .user_out        (user_gpio_out[k]),
            .user_oeb        (user_gpio_oeb[k]),
            .user_in         (user_gpio_in[k]),
            .pad_holdover    (pad_gpio_holdover[k]),
            .pad_slow_sel    (pad_gpio_slow_sel[k]),
            .pad_vtrip_sel   (pad_gpio_vtrip_sel[k]),
            .pad_inenb       (pad_gpio_inenb[k]),
            .pad_ib_mode_sel (pad_gpio_ib_mode_sel[k]),
            .pad_ana_en      (pad_gpio_ana_en[k]),
            .pad_ana_sel     (pad_gpio_ana_sel[k]),
            .pad_ana_pol     (pad_gpio_ana_pol[k]),
            .pad_dm          (pad_gpio_dm[3*k +: 3]),
            .pad_outenb      (pad_gpio_outenb[k]),
            .pad_out         (pad_gpio_out[k]),
            .pad_in          (pad_gpio_in[k])
        );
    end

endmodule

// File: tb/tb_gpio_control_bank.sv
// tb_gpio_control_bank
//   Randomized bench for gpio_control_bank (NUM_GPIO=2, STRICT_LOAD=1)
//   against a bit-queue reference model of the chain and per-channel config.
module tb_gpio_control_bank;

    localparam int NG = 2;
    localparam int P  = 13;
    localparam int T  = NG * P;
    localparam logic [T-1:0] DEFS = {13'h1803, 13'h0403};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [T-1:0]  gpio_defaults = DEFS;
    logic          shift_en = 1'b0, serial_data_in = 1'b0, serial_load = 1'b0;
    logic          serial_data_out, load_done, load_err;
`ifdef GPIO_CTRL_READBACK_EN
    logic          readback_capture = 1'b0;
`endif
    logic          user_power_good = 1'b1;
    logic [NG-1:0] mgmt_gpio_out = '0, mgmt_gpio_oeb = '0, mgmt_gpio_in;
    logic [NG-1:0] user_gpio_out = '0, user_gpio_oeb = '0, user_gpio_in;
    logic [NG-1:0] pad_gpio_holdover, pad_gpio_slow_sel, pad_gpio_vtrip_sel, pad_gpio_inenb;
    logic [NG-1:0] pad_gpio_ib_mode_sel, pad_gpio_ana_en, pad_gpio_ana_sel, pad_gpio_ana_pol;
    logic [3*NG-1:0] pad_gpio_dm;
    logic [NG-1:0] pad_gpio_outenb, pad_gpio_out;
    logic [NG-1:0] pad_gpio_in = '0;

    always #5 clk = ~clk;

    gpio_control_bank #(.NUM_GPIO(NG), .PAD_CTRL_BITS(P), .STRICT_LOAD(1'b1)) dut (
        .serial_clock(clk), .reset(reset), .gpio_defaults(gpio_defaults),
        .shift_en(shift_en), .serial_data_in(serial_data_in), .serial_load(serial_load),
        .serial_data_out(serial_data_out), .load_done(load_done), .load_err(load_err),
`ifdef GPIO_CTRL_READBACK_EN
        .readback_capture(readback_capture),
`endif
        .user_power_good(user_power_good),
        .mgmt_gpio_out(mgmt_gpio_out), .mgmt_gpio_oeb(mgmt_gpio_oeb), .mgmt_gpio_in(mgmt_gpio_in),
        .user_gpio_out(user_gpio_out), .user_gpio_oeb(user_gpio_oeb), .user_gpio_in(user_gpio_in),
        .pad_gpio_holdover(pad_gpio_holdover), .pad_gpio_slow_sel(pad_gpio_slow_sel),
        .pad_gpio_vtrip_sel(pad_gpio_vtrip_sel), .pad_gpio_inenb(pad_gpio_inenb),
        .pad_gpio_ib_mode_sel(pad_gpio_ib_mode_sel), .pad_gpio_ana_en(pad_gpio_ana_en),
        .pad_gpio_ana_sel(pad_gpio_ana_sel), .pad_gpio_ana_pol(pad_gpio_ana_pol),
        .pad_gpio_dm(pad_gpio_dm), .pad_gpio_outenb(pad_gpio_outenb),
        .pad_gpio_out(pad_gpio_out), .pad_gpio_in(pad_gpio_in)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    bit          q[$];          // bits shifted since reset, newest at back
    int          fcnt;          // bits in the current frame, saturating at T+1
    logic        esdo;
    logic [P-1:0] ecfg [NG];

    function automatic logic [T-1:0] chain_val();
        logic [T-1:0] v = '0;
        for (int i = 0; i < T; i++)
            if (q.size() > i) v[i] = q[q.size()-1-i];
        return v;
    endfunction

    task automatic model_reset();
        q.delete(); fcnt = 0; esdo = 1'b0;
        for (int k = 0; k < NG; k++) ecfg[k] = DEFS[k*P +: P];
    endtask

    task automatic model_shift(input bit b);
        logic [T-1:0] c = chain_val();
        esdo = c[T-1];
        q.push_back(b);
        if (q.size() > T) void'(q.pop_front());
        if (fcnt < T + 1) fcnt++;
    endtask

    task automatic check_pads();
        logic [3*NG-1:0] e_dm;
        logic [NG-1:0] e_oe, e_out, e_hld, e_slow, e_trip, e_inenb, e_ib, e_aen, e_asel, e_apol, e_uin;
        for (int k = 0; k < NG; k++) begin
            logic [P-1:0] c = ecfg[k];
            logic [2:0] dm = c[12:10];
            e_dm[3*k +: 3] = dm;
            e_hld[k] = c[2]; e_inenb[k] = c[3]; e_ib[k] = c[4]; e_aen[k] = c[5];
            e_asel[k] = c[6]; e_apol[k] = c[7]; e_slow[k] = c[8]; e_trip[k] = c[9];
            if (!c[0]) begin
                e_oe[k] = user_gpio_oeb[k]; e_out[k] = user_gpio_out[k];
            end else if (!mgmt_gpio_oeb[k]) begin
                e_oe[k] = 1'b0; e_out[k] = mgmt_gpio_out[k];
            end else begin
                e_oe[k] = c[1];
                if (dm == 3'b010)      e_out[k] = 1'b1;
                else if (dm == 3'b011) e_out[k] = 1'b0;
                else                   e_out[k] = mgmt_gpio_out[k];
            end
            e_uin[k] = user_power_good ? pad_gpio_in[k] : 1'b0;
        end
        chk("dm", pad_gpio_dm, e_dm);
        chk("outenb", pad_gpio_outenb, e_oe);
        chk("out", pad_gpio_out, e_out);
        chk("holdover", pad_gpio_holdover, e_hld);
        chk("slow", pad_gpio_slow_sel, e_slow);
        chk("vtrip", pad_gpio_vtrip_sel, e_trip);
        chk("inenb", pad_gpio_inenb, e_inenb);
        chk("ibmode", pad_gpio_ib_mode_sel, e_ib);
        chk("ana", {pad_gpio_ana_en, pad_gpio_ana_sel, pad_gpio_ana_pol}, {e_aen, e_asel, e_apol});
        chk("mgmt_in", mgmt_gpio_in, pad_gpio_in);
        chk("user_in", user_gpio_in, e_uin);
    endtask

    task automatic rand_io();
        mgmt_gpio_out = NG'($urandom); mgmt_gpio_oeb = NG'($urandom);
        user_gpio_out = NG'($urandom); user_gpio_oeb = NG'($urandom);
        pad_gpio_in   = NG'($urandom); user_power_good = 1'($urandom);
    endtask

    // Shift nbits of pat (MSB first), then load. simul folds the load into the
    // last shift; sic asserts shift_en during the CHECK cycle.
    task automatic do_load(input int nbits, input logic [63:0] pat, input bit simul, input bit sic);
        bit ok;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            chk("sdo", serial_data_out, esdo);
            shift_en = 1'b1; serial_data_in = pat[nbits-1-i];
            serial_load = simul && (i == nbits - 1);
            model_shift(serial_data_in);
        end
        if (!simul) begin
            @(negedge clk);
            chk("sdo", serial_data_out, esdo);
            shift_en = 1'b0; serial_load = 1'b1;
        end
        ok = (fcnt == T);
        @(negedge clk);                         // edge t passed
        chk("cnt_pre", 64'(dut.bit_cnt), 64'(fcnt));
        chk("done_early", {load_done, load_err}, 2'b00);
        serial_load = 1'b0; shift_en = sic; serial_data_in = 1'($urandom);
        @(negedge clk);                         // edge t+1 passed
        shift_en = 1'b0;
        chk("load_done", load_done, ok);
        chk("load_err", load_err, !ok);
        if (ok) begin
            logic [T-1:0] c = chain_val();
            for (int k = 0; k < NG; k++) ecfg[k] = c[k*P +: P];
        end
        fcnt = 0;
        chk("chain", 64'(dut.sr), 64'(chain_val()));
        chk("cnt_post", 64'(dut.bit_cnt), 64'd0);
        chk("sdo", serial_data_out, esdo);
        check_pads();
        @(negedge clk);
        chk("pulse_end", {load_done, load_err}, 2'b00);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_dm", pad_gpio_dm, 6'b110_001);
        chk("rst_sdo", serial_data_out, 1'b0);
        chk("rst_pulses", {load_done, load_err}, 2'b00);
        chk("rst_cnt", 64'(dut.bit_cnt), 64'd0);
        check_pads();

        // good frame, short frame, long (saturating) frame, simultaneous, shift in CHECK
        rand_io(); do_load(26, {$urandom, $urandom}, 1'b0, 1'b0);
        rand_io(); do_load(25, {$urandom, $urandom}, 1'b0, 1'b0);
        rand_io(); do_load(30, {$urandom, $urandom}, 1'b0, 1'b0);
        rand_io(); do_load(26, {$urandom, $urandom}, 1'b1, 1'b0);
        rand_io(); do_load(26, {$urandom, $urandom}, 1'b0, 1'b1);

        // pull emulation on channel 0: mgmt_en=1, oeb=1
        mgmt_gpio_oeb = 2'b01; user_power_good = 1'b1;
        do_load(26, 64'({13'h0, 13'h0803}), 1'b0, 1'b0);
        chk("pull_dn", pad_gpio_out[0], 1'b1);
        do_load(26, 64'({13'h0, 13'h0C03}), 1'b0, 1'b0);
        chk("pull_up", pad_gpio_out[0], 1'b0);
        user_power_good = 1'b0; pad_gpio_in = 2'b11;
        #1 chk("pg_gate", user_gpio_in, 2'b00);
        check_pads();

        // randomized frames
        for (int it = 0; it < 20; it++) begin
            int r = int'($urandom_range(0, 5));
            int n = (r == 0) ? 25 : (r == 1) ? 27 : (r == 2) ? 30 : 26;
            rand_io();
            do_load(n, {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // reset mid-frame, then a full frame
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); shift_en = 1'b1; serial_data_in = 1'($urandom);
        end
        @(negedge clk); shift_en = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        chk("mid_cnt", 64'(dut.bit_cnt), 64'd0);
        chk("mid_sr", 64'(dut.sr), 64'd0);
        chk("mid_sdo", serial_data_out, 1'b0);
        check_pads();
        rand_io(); do_load(26, {$urandom, $urandom}, 1'b0, 1'b0);

`ifdef GPIO_CTRL_READBACK_EN
        // readback wins over a same-cycle shift; stream the config out
        @(negedge clk); readback_capture = 1'b1; shift_en = 1'b1; serial_data_in = 1'b1;
        q.delete(); fcnt = 0;
        for (int i = T - 1; i >= 0; i--) q.push_back(ecfg[i / P][i % P]);
        @(negedge clk); readback_capture = 1'b0; shift_en = 1'b0;
        chk("rb_sr", 64'(dut.sr), 64'(chain_val()));
        do_load(26, {$urandom, $urandom}, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
